// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART byte-frame command parser with a small register file.
// Frames: 'W' addr data -> ACK/ERR, 'R' addr -> reg byte/ERR; one response byte per frame.
module uart_cmd_responder #(
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] ERR_BYTE = 8'h45
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [7:0] ctrl_out,
  output logic       busy,
  output logic [7:0] cmd_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, SEND} state_t;

  state_t              state;
  logic                is_write;
  logic [ADDR_W-1:0]   addr;
  logic                addr_ok;
  logic [7:0]          resp;
  logic [7:0]          regs [DEPTH];

  logic                take_byte;
  logic                in_addr_ok;
  logic [ADDR_W-1:0]   in_idx;

  // The FIFO strobes are decoded from the registered state so a byte is popped
  // in the same cycle its head value is captured, and a response leaves on the
  // first non-full cycle.
  assign take_byte  = !reset && !rx_empty && (state != SEND);
  assign rd_uart    = take_byte;
  assign wr_uart    = !reset && (state == SEND) && !tx_full;
  assign w_data     = wr_uart ? resp : 8'h00;
  assign busy       = (state != IDLE);
  assign ctrl_out   = regs[0];
  assign in_addr_ok = ((r_data >> ADDR_W) == 8'd0);
  assign in_idx     = r_data[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      addr      <= '0;
      addr_ok   <= 1'b0;
      resp      <= 8'h00;
      cmd_count <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (take_byte) begin
            if (r_data == OP_WRITE || r_data == OP_READ) begin
              is_write <= (r_data == OP_WRITE);
              state    <= GET_ADDR;
            end else begin
              resp  <= ERR_BYTE;
              state <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (take_byte) begin
            if (is_write) begin
              addr    <= in_idx;
              addr_ok <= in_addr_ok;
              state   <= GET_DATA;
            end else begin
              resp  <= in_addr_ok ? regs[in_idx] : ERR_BYTE;
              state <= SEND;
            end
          end
        end
        GET_DATA: begin
          // An out-of-range write still consumes its data byte so the stream stays framed.
          if (take_byte) begin
            if (addr_ok) begin
              regs[addr] <= r_data;
              resp       <= ACK_BYTE;
            end else begin
              resp <= ERR_BYTE;
            end
            state <= SEND;
          end
        end
        SEND: begin
          if (!tx_full) begin
            cmd_count <= cmd_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - self-checking bench for uart_cmd_responder.
// A byte-stream frame model predicts responses; literal checks pin the model.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       tx_full = 1'b0;
  logic       rd_uart, wr_uart, busy;
  logic [7:0] w_data, ctrl_out, cmd_count;

  uart_cmd_responder dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .ctrl_out(ctrl_out),
    .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] wlog[$];
  logic [7:0] mreg[16];
  int         nb = 0;
  logic [7:0] mop, maddr;
  logic [7:0] mcount = 8'h00;
  int         rd_pulses = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         s_rd = 1'b0, s_wr = 1'b0;
  logic [7:0] s_byte, s_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic refresh();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = 8'h00;
    nb = 0;
    expq.delete();
    mcount = 8'h00;
  endtask

  // Frame semantics at the byte-stream level: every completed frame queues one response.
  task automatic model_byte(input logic [7:0] b);
    case (nb)
      0: if (b == 8'h57 || b == 8'h52) begin mop = b; nb = 1; end
         else expq.push_back(8'h45);
      1: if (mop == 8'h52) begin
           expq.push_back(b < 8'd16 ? mreg[b[3:0]] : 8'h45);
           nb = 0;
         end else begin
           maddr = b; nb = 2;
         end
      default: begin
        if (maddr < 8'd16) begin mreg[maddr[3:0]] = b; expq.push_back(8'h4B); end
        else expq.push_back(8'h45);
        nb = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    chk("rd_uart", 32'(rd_uart), 32'(!reset && !rx_empty && expq.size() == 0));
    chk("wr_uart", 32'(wr_uart), 32'(!reset && expq.size() != 0 && !tx_full));
    if (wr_uart && expq.size() != 0) chk("w_data", 32'(w_data), 32'(expq[0]));
    chk("strobe_excl", 32'(rd_uart && wr_uart), 32'(0));
    chk("busy", 32'(busy), 32'(nb != 0 || expq.size() != 0));
    chk("ctrl_out", 32'(ctrl_out), 32'(mreg[0]));
    chk("cmd_count", 32'(cmd_count), 32'(mcount));
    if (reset) chk("w_data_rst", 32'(w_data), 32'(0));
    s_rd    = rd_uart;
    s_wr    = wr_uart;
    s_byte  = r_data;
    s_wdata = w_data;
  end

  always @(posedge clk) begin
    #1;
    if (s_rd) begin
      void'(rxq.pop_front());
      rd_pulses++;
      model_byte(s_byte);
    end
    if (s_wr) begin
      wlog.push_back(s_wdata);
      if (expq.size() != 0) void'(expq.pop_front());
      mcount = mcount + 8'd1;
    end
    s_rd = 1'b0;
    s_wr = 1'b0;
    refresh();
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    refresh();
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while (!(rxq.size() == 0 && expq.size() == 0 && nb == 0) && k < limit) begin
      tick(1);
      k++;
    end
    chk(name, 32'(k < limit), 32'(1));
    tick(1);
  endtask

  function automatic logic [7:0] last(input int back);
    return wlog[wlog.size() - 1 - back];
  endfunction

  int r0, n0;

  initial begin
    refresh();
    tick(2);
    push(8'h52); push(8'h03);
    tick(2);
    chk("rst_rd_uart", 32'(rd_uart), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cmd_count", 32'(cmd_count), 32'(0));
    chk("rst_ctrl_out", 32'(ctrl_out), 32'(0));
    chk("rst_w_data", 32'(w_data), 32'(0));
    reset = 1'b0;

    drain("drain_r03", 50);
    chk("r03_resp", 32'(last(0)), 32'h00);
    chk("r03_count", 32'(cmd_count), 32'd1);

    push(8'h57); push(8'h00); push(8'hA5);
    drain("drain_w00", 50);
    chk("w00_resp", 32'(last(0)), 32'h4B);
    chk("w00_ctrl", 32'(ctrl_out), 32'hA5);
    push(8'h52); push(8'h00);
    drain("drain_r00", 50);
    chk("r00_resp", 32'(last(0)), 32'hA5);
    chk("r00_count", 32'(cmd_count), 32'd3);

    r0 = rd_pulses;
    push(8'h11);
    drain("drain_bad_op", 50);
    chk("bad_op_resp", 32'(last(0)), 32'h45);
    chk("bad_op_pops", 32'(rd_pulses - r0), 32'd1);
    push(8'h52); push(8'h00);
    drain("drain_after_bad", 50);
    chk("after_bad_resp", 32'(last(0)), 32'hA5);

    r0 = rd_pulses;
    push(8'h57); push(8'h20); push(8'h77);
    drain("drain_bad_addr", 50);
    chk("bad_addr_resp", 32'(last(0)), 32'h45);
    chk("bad_addr_pops", 32'(rd_pulses - r0), 32'd3);
    chk("bad_addr_ctrl", 32'(ctrl_out), 32'hA5);

    push(8'h57); push(8'h0F); push(8'h3C);
    push(8'h52); push(8'h0F);
    push(8'h52); push(8'h10);
    drain("drain_edges", 80);
    chk("edge_w0f", 32'(last(2)), 32'h4B);
    chk("edge_r0f", 32'(last(1)), 32'h3C);
    chk("edge_r10", 32'(last(0)), 32'h45);

    tx_full = 1'b1;
    n0 = wlog.size();
    push(8'h52); push(8'h0F);
    tick(12);
    chk("full_busy", 32'(busy), 32'(1));
    chk("full_no_tx", 32'(wlog.size()), 32'(n0));
    tx_full = 1'b0;
    tick(1);
    chk("full_one_tx", 32'(wlog.size()), 32'(n0 + 1));
    chk("full_resp", 32'(last(0)), 32'h3C);

    push(8'h57); push(8'h05); push(8'h5A);
    drain("drain_w05", 50);
    push(8'h57); push(8'h05);
    tick(3);
    chk("mid_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    tick(2);
    chk("mid_rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    push(8'h52); push(8'h05);
    drain("drain_r05", 50);
    chk("r05_resp", 32'(last(0)), 32'h00);
    chk("r05_count", 32'(cmd_count), 32'd1);

    for (int i = 0; i < 256; i++) push(8'hFF);
    drain("drain_wrap", 700);
    chk("wrap_count", 32'(cmd_count), 32'd1);
    chk("wrap_resp", 32'(last(0)), 32'h45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
